// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register: load-use hazard stall plus bubble insertion, and saturating stall/flush counters.
// Latency 1 cycle ID->EX; on a load-use hazard PC and IF/ID hold for one cycle while a bubble enters EX.
module id_ex_pipe #(
  parameter int DATA_W = 64,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_rn,
  input  logic [REG_W-1:0]  id_rm,
  input  logic              id_uses_rm,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [DATA_W-1:0] id_a,
  input  logic [DATA_W-1:0] id_b,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [8:0]        id_ctrl,
  input  logic              flush,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              stall,
  output logic              ex_valid,
  output logic [REG_W-1:0]  ex_rn,
  output logic [REG_W-1:0]  ex_rm,
  output logic [REG_W-1:0]  ex_rd,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic [8:0]        ex_ctrl,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       set_flags;
    logic [2:0] alu_op;
  } ctrl_t;

  localparam logic [REG_W-1:0] XZR = {REG_W{1'b1}};

  ctrl_t ex_ctrl_q;
  logic  hz;
  logic  bubble;

  assign ex_ctrl = ex_ctrl_q;

  // XZR as a load destination is never a real dependency.
  assign hz = ex_valid & ex_ctrl_q.mem_read & (ex_rd != XZR) & id_valid &
              ((ex_rd == id_rn) | (id_uses_rm & (ex_rd == id_rm)));

  assign stall       = hz & ~flush;
  assign pc_write    = ~stall;
  assign if_id_write = ~stall;
  assign bubble      = flush | stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid  <= 1'b0;
      ex_rn     <= '0;
      ex_rm     <= '0;
      ex_rd     <= '0;
      ex_a      <= '0;
      ex_b      <= '0;
      ex_imm    <= '0;
      ex_ctrl_q <= '0;
    end else if (bubble) begin
      ex_valid  <= 1'b0;
      ex_rn     <= '0;
      ex_rm     <= '0;
      ex_rd     <= '0;
      ex_a      <= '0;
      ex_b      <= '0;
      ex_imm    <= '0;
      ex_ctrl_q <= '0;
    end else begin
      ex_valid  <= id_valid;
      ex_rn     <= id_rn;
      ex_rm     <= id_rm;
      ex_rd     <= id_rd;
      ex_a      <= id_a;
      ex_b      <= id_b;
      ex_imm    <= id_imm;
      ex_ctrl_q <= id_valid ? ctrl_t'(id_ctrl) : '0;
    end
  end

  // Event counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush && (flush_cnt != {CNT_W{1'b1}}))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/id_ex_pipe.md
Name: id_ex_pipe

Overview:
- ID/EX pipeline register for the pipelined LEGv8 core, with integrated load-use hazard detection and bubble insertion.
- Captures decoded operands, register specifiers and control bits from ID, and presents them to the EX stage.
- Its ex_rn/ex_rm outputs drive the EX-stage forwarding unit's source-register inputs.
- Generates the PC and IF/ID write enables, and keeps saturating stall and flush event counters.

Parameters:
- DATA_W, 64, operand/immediate width
- REG_W, 5, register specifier width
- CNT_W, 32, width of the stall and flush event counters

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- id_valid  input  1  ID holds a real instruction
- id_rn  input  REG_W  first source register
- id_rm  input  REG_W  second source register, already Reg2Loc-selected (Rm, or Rd for STUR/CBZ)
- id_uses_rm  input  1  instruction reads id_rm
- id_rd  input  REG_W  destination register
- id_a  input  DATA_W  register-file read data 1
- id_b  input  DATA_W  register-file read data 2
- id_imm  input  DATA_W  sign-extended immediate
- id_ctrl  input  9  {RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, SetFlags, ALUOp[2:0]}
- flush  input  1  taken-branch squash from EX/MEM
- pc_write  output  1  PC update enable
- if_id_write  output  1  IF/ID register load enable
- stall  output  1  load-use stall in progress this cycle
- ex_valid  output  1  EX holds a real instruction
- ex_rn, ex_rm, ex_rd  output  REG_W  registered specifiers
- ex_a, ex_b, ex_imm  output  DATA_W  registered operands
- ex_ctrl  output  9  registered control, same bit order as id_ctrl
- stall_cnt  output  CNT_W  count of stall cycles
- flush_cnt  output  CNT_W  count of flush cycles

Behaviour:
- Reset (async, any time): every registered output goes to 0, including both counters. ex_valid=0 and ex_ctrl=0 is a bubble. Outputs stay 0 until the first rising edge after reset deasserts.
- Hazard detection is combinational on current EX contents and ID inputs:
  - hz = ex_valid & ex_ctrl.MemRead & (ex_rd != 31) & id_valid & ((ex_rd == id_rn) | (id_uses_rm & (ex_rd == id_rm)))
- Stall and enables:
  - stall = hz & ~flush
  - pc_write = ~stall, if_id_write = ~stall
  - During reset, pc_write = if_id_write = 1.
- Register update at each rising edge, in priority order:
  1. flush=1: load bubble. Specifiers, operands and ctrl = 0; ex_valid = 0.
  2. stall=1: load bubble. ID contents are held upstream by the deasserted enables.
  3. Otherwise: capture all id_* fields. ex_valid = id_valid. ex_ctrl = id_ctrl if id_valid, else 0.
- A stall lasts exactly 1 cycle per load-use pair. The inserted bubble clears hz on the next cycle, and forwarding from MEM/WB then supplies the value.
- X31 destination never causes a stall; XZR is not a real dependency.
- Counters:
  - stall_cnt += 1 on every cycle with stall=1.
  - flush_cnt += 1 on every cycle with flush=1.
  - Both saturate at all-ones with no wrap.
  - Both clear only on reset.
- flush and hz together: flush wins. stall=0, one bubble is inserted, stall_cnt does not increment, flush_cnt does.
- Latency is 1 cycle from ID to EX. There is no combinational path from id_* to ex_* outputs.

Test Plan:
- Reset mid-stream: with ex_valid=1 and ex_ctrl=9'h1FF, assert reset asynchronously between edges -> all ex_* outputs and both counters read 0 immediately; pc_write=1.
- Pass-through: id_valid=1, rn=2, rm=3, rd=4, a=5, b=7, ctrl=9'h100 -> next edge ex_rn=2, ex_rm=3, ex_rd=4, ex_a=5, ex_b=7, ex_ctrl=9'h100; stall stays 0.
- Load-use: LDUR X1 in EX, then ADD X2,X1,X3 in ID -> stall=1 and pc_write=0 for exactly 1 cycle; next edge loads a bubble (ex_ctrl=0); on the following edge the ADD is captured; stall_cnt=1.
- Non-hazards, each -> stall=0 and no bubble:
  - LDUR X31 in EX, ID reads X31.
  - LDUR X1 in EX, ID reads X1 only as rm with id_uses_rm=0.
- Flush with simultaneous hazard -> stall=0, bubble loaded, flush_cnt=1, stall_cnt=0.
- Saturation: CNT_W=2, force 5 consecutive stall cycles -> stall_cnt ends at 3, not 1.
